// File: rtl/estado_mascota.sv
// Pet mood classifier: filters need levels into a stable mood code,
// with a change strobe and an alert LED drive.
module estado_mascota #(
  parameter int CLK_FREQ    = 50000000,
  parameter int TICK_DIV    = 50000000,
  parameter int DWELL_TICKS = 3,
  parameter int BLINK_DIV   = 12500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] nivel_hambre,
  input  logic [2:0] nivel_diversion,
  input  logic       test,
  output logic [2:0] estado,
  output logic       cambio,
  output logic       led_alerta
);

  typedef enum logic [2:0] {
    FELIZ      = 3'd0,
    NEUTRO     = 3'd1,
    HAMBRIENTO = 3'd2,
    ABURRIDO   = 3'd3,
    ENFERMO    = 3'd4
  } mood_e;

  localparam int TW = $clog2(TICK_DIV);
  localparam int DW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [TW-1:0] TICK_MAX  = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DWELL_MAX = DW'(DWELL_TICKS - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

  if (CLK_FREQ < 1) begin : g_clk_freq_doc
  end

  logic [2:0]    h_q, h_d, d_q, d_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic [DW-1:0] dwell_q, dwell_d;
  mood_e         pending_q, pending_d;
  mood_e         estado_q, estado_d;
  mood_e         cand;
  logic          cambio_q, cambio_d;
  logic          led_q, led_d;
  logic          tick;
  logic          blink_wrap;

  function automatic logic [2:0] clamp(input logic [2:0] v);
    logic [2:0] r;
    r = v;
    if (v == 3'd0) r = 3'd1;
    if (v > 3'd5) r = 3'd5;
    return r;
  endfunction

  function automatic mood_e next_mood(input mood_e m);
    mood_e r;
    unique case (m)
      FELIZ:      r = NEUTRO;
      NEUTRO:     r = HAMBRIENTO;
      HAMBRIENTO: r = ABURRIDO;
      ABURRIDO:   r = ENFERMO;
      default:    r = FELIZ;
    endcase
    return r;
  endfunction

  always_comb begin
    h_d = clamp(nivel_hambre);
    d_d = clamp(nivel_diversion);

    tick        = (tick_cnt_q == TICK_MAX);
    tick_cnt_d  = tick ? '0 : tick_cnt_q + TW'(1);
    blink_wrap  = (blink_cnt_q == BLINK_MAX);
    blink_cnt_d = blink_wrap ? '0 : blink_cnt_q + BW'(1);

    // Priority order matters: ENFERMO overlaps the HAMBRIENTO/ABURRIDO rules
    if (h_q == 3'd5 && d_q == 3'd1)      cand = ENFERMO;
    else if (h_q >= 3'd4)                cand = HAMBRIENTO;
    else if (d_q <= 3'd2)                cand = ABURRIDO;
    else if (h_q <= 3'd2 && d_q >= 3'd4) cand = FELIZ;
    else                                 cand = NEUTRO;
  end

  always_comb begin
    pending_d = pending_q;
    dwell_d   = dwell_q;
    estado_d  = estado_q;
    cambio_d  = 1'b0;
    led_d     = 1'b0;

    if (!test) begin
      // Tracking the candidate here makes release resume cleanly
      pending_d = cand;
      dwell_d   = '0;
      if (tick) begin
        estado_d = next_mood(estado_q);
        cambio_d = 1'b1;
      end
    end else if (cand != pending_q) begin
      pending_d = cand;
      dwell_d   = '0;
    end else if (pending_q == estado_q ||
                 (estado_q == ENFERMO && pending_q != FELIZ)) begin
      dwell_d = '0;
    end else if (tick) begin
      if (dwell_q == DWELL_MAX) begin
        estado_d = pending_q;
        dwell_d  = '0;
        cambio_d = 1'b1;
      end else begin
        dwell_d = dwell_q + DW'(1);
      end
    end

    unique case (estado_d)
      ENFERMO: led_d = 1'b1;
      HAMBRIENTO, ABURRIDO: begin
        if (estado_d != estado_q) led_d = 1'b0;
        else if (blink_wrap)      led_d = ~led_q;
        else                      led_d = led_q;
      end
      default: led_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      h_q         <= 3'd1;
      d_q         <= 3'd5;
      tick_cnt_q  <= '0;
      blink_cnt_q <= '0;
      dwell_q     <= '0;
      pending_q   <= FELIZ;
      estado_q    <= FELIZ;
      cambio_q    <= 1'b0;
      led_q       <= 1'b0;
    end else begin
      h_q         <= h_d;
      d_q         <= d_d;
      tick_cnt_q  <= tick_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      dwell_q     <= dwell_d;
      pending_q   <= pending_d;
      estado_q    <= estado_d;
      cambio_q    <= cambio_d;
      led_q       <= led_d;
    end
  end

  assign estado     = estado_q;
  assign cambio     = cambio_q;
  assign led_alerta = led_q;

endmodule
